param_shift_register: RTL and testbench
=======================================

PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (>=2).
REQ-002 Parameter LEN_W, default 4, width of burst length field.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  3  operation select: HOLD=0, SHL=1, SHR=2, ROTL=3, ROTR=4, LOAD=5, codes 6-7 treated as HOLD.
REQ-006 serial_in  input  1  bit entering on SHL (at bit 0) or SHR (at bit WIDTH-1).
REQ-007 parallel_in  input  WIDTH  value captured on LOAD.
REQ-008 shift_enable  input  1  single-step strobe, one operation per cycle while high.
REQ-009 burst_start  input  1  request for an autonomous multi-step burst.
REQ-010 burst_len  input  LEN_W  number of burst steps, sampled with burst_start.
REQ-011 stored_data  output  WIDTH  register contents.
REQ-012 serial_out  output  1  registered copy of the last bit shifted or rotated out.
REQ-013 busy  output  1  high while a burst is running.
REQ-014 done  output  1  one-cycle pulse on burst completion.

Function
REQ-015 FSM states IDLE, RUN, DONE; stored_data changes only on a rising clk edge.
REQ-016 IDLE, shift_enable=1, burst_start=0: apply mode once: SHL {d[W-2:0],serial_in}; SHR {serial_in,d[W-1:1]}; ROTL {d[W-2:0],d[W-1]}; ROTR {d[0],d[W-1:1]}; LOAD parallel_in; HOLD unchanged.
REQ-017 serial_out updates on each SHL/ROTL step to the old d[W-1] and on each SHR/ROTR step to the old d[0]; unchanged on LOAD/HOLD.
REQ-018 IDLE, burst_start=1, burst_len>0, mode in {SHL,SHR,ROTL,ROTR}: capture mode and burst_len, enter RUN; no data change that cycle; burst_start beats shift_enable.
REQ-019 burst_start with burst_len=0 or mode in {HOLD,LOAD,6,7}: ignored as a burst; shift_enable then handled per REQ-016.
REQ-020 RUN: one step per cycle of the captured mode (serial_in sampled live each cycle), counter decrements; after exactly burst_len steps move to DONE.
REQ-021 RUN: mode, shift_enable, burst_start, burst_len ignored; busy=1 for exactly burst_len cycles.
REQ-022 DONE: done=1, busy=0, no data change, return to IDLE next cycle; inputs ignored in DONE.
REQ-023 Max burst 2^LEN_W-1 steps; counter never wraps.

Reset
REQ-024 reset_n low asynchronously forces stored_data=0, serial_out=0, busy=0, done=0, state=IDLE, counter=0, including mid-burst.
REQ-025 After reset_n deasserts, the first operation occurs on the first rising edge with reset_n high.

Structure
REQ-026 Package shift_pkg holds mode encodings and the FSM state enum.
REQ-027 Burst FSM plus counter in sub-module shift_burst_ctrl; datapath in the top module.

Verification (WIDTH=8, LEN_W=4)
REQ-028 Reset, then 3 cycles SHL single-step with serial_in 1,0,1 -> stored_data 0x05, serial_out 0.
REQ-029 LOAD 0xA5, burst_start ROTR len 4 -> busy high 4 cycles, stored_data 0x5A, done pulse 1 cycle, then IDLE.
REQ-030 LOAD 0x81, SHR step with serial_in 0 -> stored_data 0x40, serial_out 1.
REQ-031 burst_start with len 0, or with mode LOAD -> busy and done never assert; shift_enable step still applied.
REQ-032 Burst SHL len 8 from 0xFF with serial_in 0, reset_n low after step 3 -> immediately 0x00, busy 0, done 0; no resume.
REQ-033 During RUN toggle shift_enable, mode and burst_start -> final value identical to undisturbed burst.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the parameterised shift register: operation modes,
// burst FSM states and a helper that classifies burst-capable modes.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'd4;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only the four movement modes may run as an autonomous burst.
    function automatic logic is_burst_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: decides each cycle whether the datapath steps and with
// which mode, and runs the counted RUN/DONE sequence for bursts.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned LEN_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              shift_enable,
    input  logic              burst_start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              step_c,
    output logic [MODE_W-1:0] step_mode_c,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        step_c      = 1'b0;
        step_mode_c = mode;

        case (state_q)
            ST_IDLE: begin
                // An accepted burst wins over a single step and moves no data.
                if (burst_start && (burst_len != '0) && is_burst_mode(mode)) begin
                    state_d = ST_RUN;
                    cnt_d   = burst_len;
                    mode_d  = mode;
                end else if (shift_enable) begin
                    step_c = 1'b1;
                end
            end
            ST_RUN: begin
                step_c      = 1'b1;
                step_mode_c = mode_q;
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/param_shift_register.sv
// Parameterised shift/rotate/load register with single-step and counted
// burst operation; the burst sequencing lives in shift_burst_ctrl.
module param_shift_register
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              serial_in,
    input  logic [WIDTH-1:0]  parallel_in,
    input  logic              shift_enable,
    input  logic              burst_start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [WIDTH-1:0]  stored_data,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    logic              step_c;
    logic [MODE_W-1:0] step_mode_c;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              sout_q, sout_d;

    shift_burst_ctrl #(
        .LEN_W (LEN_W)
    ) u_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .shift_enable (shift_enable),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .step_c       (step_c),
        .step_mode_c  (step_mode_c),
        .busy         (busy),
        .done         (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            sout_q <= 1'b0;
        end else begin
            data_q <= data_d;
            sout_q <= sout_d;
        end
    end

    // One operation of the selected mode; undefined codes behave as HOLD.
    always_comb begin
        data_d = data_q;
        sout_d = sout_q;
        if (step_c) begin
            case (step_mode_c)
                MODE_SHL: begin
                    data_d = {data_q[WIDTH-2:0], serial_in};
                    sout_d = data_q[WIDTH-1];
                end
                MODE_SHR: begin
                    data_d = {serial_in, data_q[WIDTH-1:1]};
                    sout_d = data_q[0];
                end
                MODE_ROTL: begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    sout_d = data_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                    sout_d = data_q[0];
                end
                MODE_LOAD: begin
                    data_d = parallel_in;
                end
                default: begin
                    data_d = data_q;
                end
            endcase
        end
    end

    assign stored_data = data_q;
    assign serial_out  = sout_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Randomised scoreboard bench for param_shift_register against a queue-based
// behavioural model; directed scenarios cover reset, bursts and ignored requests.
module tb_param_shift_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       mode = '0;
    logic             serial_in = 1'b0;
    logic [WIDTH-1:0] parallel_in = '0;
    logic             shift_enable = 1'b0;
    logic             burst_start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic [WIDTH-1:0] stored_data;
    logic             serial_out;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    param_shift_register #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .serial_in    (serial_in),
        .parallel_in  (parallel_in),
        .shift_enable (shift_enable),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .stored_data  (stored_data),
        .serial_out   (serial_out),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sout;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: register value plus a queue of pending burst steps.
    logic [WIDTH-1:0] m_data = '0;
    logic             m_sout = 1'b0;
    logic [2:0]       m_steps[$];
    bit               m_prev_done = 1'b0;

    function automatic void model_apply(input logic [2:0] md, input logic sin,
                                        input logic [WIDTH-1:0] pin);
        int unsigned d;
        int unsigned top;
        d   = int'(m_data);
        top = (d >> (WIDTH - 1)) & 1;
        case (md)
            3'd1: begin m_sout = top[0];   m_data = WIDTH'((d << 1) | 32'(sin)); end
            3'd2: begin m_sout = m_data[0]; m_data = WIDTH'((d >> 1) | (32'(sin) << (WIDTH - 1))); end
            3'd3: begin m_sout = top[0];   m_data = WIDTH'((d << 1) | top); end
            3'd4: begin m_sout = m_data[0]; m_data = WIDTH'((d >> 1) | ((d & 1) << (WIDTH - 1))); end
            3'd5: m_data = pin;
            default: ;
        endcase
    endfunction

    function automatic bit movement(input logic [2:0] md);
        return md >= 3'd1 && md <= 3'd4;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive at the falling edge, predict the next rising edge.
    task automatic cycle(input logic rst, input logic [2:0] md, input logic se,
                         input logic bs, input logic [LEN_W-1:0] bl, input logic sin,
                         input logic [WIDTH-1:0] pin);
        exp_t e;
        bit   ed;
        @(negedge clk);
        mode = md; shift_enable = se; burst_start = bs; burst_len = bl;
        serial_in = sin; parallel_in = pin;
        ed = 1'b0;
        if (!rst) begin
            reset_n = 1'b0;
            m_data = '0; m_sout = 1'b0; m_steps.delete(); m_prev_done = 1'b0;
            #1;
            chk("async_reset_data", int'(stored_data), 0);
            chk("async_reset_flags", int'({serial_out, busy, done}), 0);
        end else begin
            reset_n = 1'b1;
            if (m_steps.size() > 0) begin
                model_apply(m_steps.pop_front(), sin, pin);
                ed = (m_steps.size() == 0);
            end else if (m_prev_done) begin
                ed = 1'b0;
            end else if (bs && bl != 0 && movement(md)) begin
                for (int i = 0; i < int'(bl); i++) m_steps.push_back(md);
            end else if (se) begin
                model_apply(md, sin, pin);
            end
            m_prev_done = ed;
        end
        e.data = m_data; e.sout = m_sout; e.busy = (m_steps.size() > 0); e.done = ed;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge yields one observed output vector.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (stored_data !== e.data || serial_out !== e.sout ||
                busy !== e.busy || done !== e.done) begin
                n_err++;
                $display("FAIL scoreboard: got data=%h sout=%b busy=%b done=%b expected data=%h sout=%b busy=%b done=%b at %0t",
                         stored_data, serial_out, busy, done, e.data, e.sout, e.busy, e.done, $time);
            end
        end
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int guard;

        cycle(1'b0, 3'd0, 0, 0, 0, 0, 0);
        cycle(1'b0, 3'd0, 0, 0, 0, 0, 0);

        // Three SHL single steps with serial_in 1,0,1.
        cycle(1'b1, 3'd1, 1, 0, 0, 1, 0);
        cycle(1'b1, 3'd1, 1, 0, 0, 0, 0);
        cycle(1'b1, 3'd1, 1, 0, 0, 1, 0);
        settle();
        chk("shl_value", int'(stored_data), 'h05);
        chk("shl_sout", int'(serial_out), 0);

        // LOAD 0xA5 then ROTR burst of 4.
        cycle(1'b1, 3'd5, 1, 0, 0, 0, 8'hA5);
        cycle(1'b1, 3'd4, 1, 1, 4, 0, 0);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'd0, 0, 0, 0, 0, 0);
            #2;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk("rotr_burst_busy_cycles", busy_cnt, 4);
        chk("rotr_burst_done_pulses", done_cnt, 1);
        chk("rotr_burst_value", int'(stored_data), 'h5A);

        // LOAD 0x81 then one SHR with serial_in 0.
        cycle(1'b1, 3'd5, 1, 0, 0, 0, 8'h81);
        cycle(1'b1, 3'd2, 1, 0, 0, 0, 0);
        settle();
        chk("shr_value", int'(stored_data), 'h40);
        chk("shr_sout", int'(serial_out), 1);

        // Ignored burst requests: zero length, and LOAD mode.
        busy_cnt = 0;
        cycle(1'b1, 3'd1, 1, 1, 0, 1, 0);
        #2; if (busy || done) busy_cnt++;
        cycle(1'b1, 3'd5, 1, 1, 5, 0, 8'h3C);
        #2; if (busy || done) busy_cnt++;
        cycle(1'b1, 3'd0, 0, 0, 0, 0, 0);
        #2; if (busy || done) busy_cnt++;
        chk("ignored_burst_flags", busy_cnt, 0);
        chk("ignored_burst_load", int'(stored_data), 'h3C);

        // Burst disturbed by random inputs ends as if undisturbed.
        cycle(1'b1, 3'd3, 0, 1, 5, 0, 0);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  LEN_W'($urandom), 1'($urandom), WIDTH'($urandom));
        cycle(1'b1, 3'd0, 0, 0, 0, 0, 0);
        settle();
        chk("disturbed_burst_value", int'(stored_data), 'h87);

        // SHL burst of 8 from 0xFF, reset after the third step.
        cycle(1'b1, 3'd5, 1, 0, 0, 0, 8'hFF);
        cycle(1'b1, 3'd1, 0, 1, 8, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 0, 0, 0, 0, 0);
        cycle(1'b0, 3'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'd0, 0, 0, 0, 0, 0);
        settle();
        chk("no_resume_value", int'(stored_data), 0);
        chk("no_resume_busy", int'(busy), 0);

        // Random traffic including bursts, unsupported codes and resets.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom), ($urandom_range(0, 3) == 0), LEN_W'($urandom),
                  1'($urandom), WIDTH'($urandom));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
